// File: rtl/rr_grant_scheduler_if.sv
// Purpose: request/grant bundle between requester agents and the round-robin scheduler.
// Latency: n/a (wiring only).
// Backpressure: level-based; requesters hold req until they are granted and finished.
interface rr_grant_scheduler_if #(
  parameter int N   = 4,
  parameter int IDW = 2
) ();
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           preempt;

  // Scheduler side: consumes requests, drives the grant outputs.
  modport master (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output preempt
  );

  // Requester side: drives requests, observes grants.
  modport slave (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  preempt
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Purpose: round-robin owner selection for one shared resource among N requesters, with bounded hold and preemption.
// Latency: grant appears one cycle after req is sampled in IDLE; an owner change costs exactly one GAP cycle.
// Backpressure: req is a level held by each requester; non-owners wait until release, preemption or their turn.
module rr_grant_scheduler #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  rr_grant_scheduler_if.master     bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [7:0]     hold_cnt, hold_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic [IDW-1:0] gnt_id_q, gnt_id_nxt;
  logic           busy_q, busy_nxt;
  logic           preempt_q, preempt_nxt;

  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           any_req;
  logic           owner_release;
  logic           owner_preempt;

  assign any_req       = |bus.req;
  // Owner dropping its request always takes precedence over a preemption.
  assign owner_release = ~bus.req[gnt_id_q];
  assign owner_preempt = bus.req[gnt_id_q] && (hold_cnt == 8'(MAX_HOLD)) && |(bus.req & ~gnt_q);

  // Rotating-priority search: first active request at or after ptr, wrapping modulo N.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IDW'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_q     <= gnt_nxt;
      gnt_id_q  <= gnt_id_nxt;
      busy_q    <= busy_nxt;
      preempt_q <= preempt_nxt;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (owner_release || owner_preempt) state_nxt = GAP;
      GAP:     state_nxt = any_req ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt_q;
    gnt_id_nxt  = gnt_id_q;
    busy_nxt    = busy_q;
    preempt_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          gnt_nxt    = {{(N-1){1'b0}}, 1'b1} << win;
          gnt_id_nxt = win;
          busy_nxt   = 1'b1;
          hold_nxt   = 8'd1;
        end else begin
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (owner_release || owner_preempt) begin
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = gnt_id_q + 1'b1;
          preempt_nxt = ~owner_release;
        end else if (hold_cnt != 8'(MAX_HOLD)) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (N=4, MAX_HOLD=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rr_grant_scheduler;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  bit   mon_en;

  rr_grant_scheduler_if #(.N(4), .IDW(2)) bus ();

  rr_grant_scheduler #(.N(4), .MAX_HOLD(8), .IDW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Structural invariants, every cycle outside reset.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      checks++;
      if (!$onehot0(bus.gnt) || (bus.busy !== (|bus.gnt)) ||
          (bus.busy && bus.gnt[bus.gnt_id] !== 1'b1) ||
          (bus.preempt && bus.gnt !== 4'b0000)) begin
        errors++;
        $display("FAIL invariant t=%0t gnt=%b gnt_id=%0d busy=%b preempt=%b", $time,
                 bus.gnt, bus.gnt_id, bus.busy, bus.preempt);
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d gnt=%b busy=%b preempt=%b want 0000/0/0", i, bus.gnt, bus.busy, bus.preempt);
      end
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant gnt=%b id=%0d busy=%b want 0001/0/1", bus.gnt, bus.gnt_id, bus.busy);
    end
    // Release brings GAP then IDLE; pointer advances to 1.
    bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d gnt=%b busy=%b want 0000/0", i, bus.gnt, bus.busy);
      end
    end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL single_hold cyc=%0d gnt=%b id=%0d preempt=%b want 0100/2/0", i, bus.gnt, bus.gnt_id, bus.preempt);
      end
    end
    bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL single_drop cyc=%0d gnt=%b busy=%b preempt=%b want 0000/0/0", i, bus.gnt, bus.busy, bus.preempt);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      want = 4'b0001 << k;
      for (int c = 0; c < 2; c++) begin
        @(negedge clock);
        checks++;
        if (bus.gnt !== want || bus.gnt_id !== 2'(k)) begin
          errors++;
          $display("FAIL fair_owner k=%0d cyc=%0d gnt=%b id=%0d want %b/%0d", k, c, bus.gnt, bus.gnt_id, want, k);
        end
      end
      bus.req = 4'b1111 & ~want;
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL fair_gap k=%0d gnt=%b preempt=%b want 0000/0", k, bus.gnt, bus.preempt);
      end
      bus.req = 4'b1111;
    end
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL fair_wrap gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
    end
  endtask

  task automatic test_preempt_wrap();
    do_reset();
    bus.req = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL preempt_hold cyc=%0d gnt=%b preempt=%b want 0010/0", i, bus.gnt, bus.preempt);
      end
      if (i == 3) bus.req = 4'b1010;
    end
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_pulse gnt=%b preempt=%b busy=%b want 0000/1/0", bus.gnt, bus.preempt, bus.busy);
    end
    // Owner 3 now holds; req[0] waits but hold is below the limit until the release.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      checks++;
      if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL wrap_hold cyc=%0d gnt=%b id=%0d preempt=%b want 1000/3/0", i, bus.gnt, bus.gnt_id, bus.preempt);
      end
      bus.req = (i == 8) ? 4'b0011 : 4'b1001;
    end
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release gnt=%b preempt=%b want 0000/0", bus.gnt, bus.preempt);
    end
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_grant gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
    end
  endtask

  task automatic test_reset_mid();
    // Owner 0 releases (ptr -> 1), owner 1 takes over.
    bus.req = 4'b0010;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_setup gnt=%b want 0010", bus.gnt);
    end
    reset   = 1'b1;
    bus.req = 4'b0011;
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset gnt=%b preempt=%b busy=%b want 0000/0/0", bus.gnt, bus.preempt, bus.busy);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_ptr gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    mon_en  = 1'b0;
    reset   = 1'b1;
    bus.req = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_preempt_wrap();
    test_reset_mid();
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
